// File: rtl/square_renderer_pkg.sv
// Shared attribute-record layout and defaults for the square renderer.
// Record is {en, colour, y_top, x_left}; x_left sits at bit 0.
package square_renderer_pkg;

    localparam int VGA_COORD_W = 10;
    localparam int DEF_RGB_W   = 12;
    localparam logic [11:0] DEF_BG_RGB = 12'hF00;

    localparam int X_LSB = 0;

    function automatic int y_lsb(input int coord_w);
        return coord_w;
    endfunction

    function automatic int rgb_lsb(input int coord_w);
        return 2 * coord_w;
    endfunction

    function automatic int en_bit(input int coord_w, input int rgb_w);
        return 2 * coord_w + rgb_w;
    endfunction

    function automatic int attr_w(input int coord_w, input int rgb_w);
        return 2 * coord_w + rgb_w + 1;
    endfunction

    localparam int ATTR_W = attr_w(VGA_COORD_W, DEF_RGB_W);

endpackage

// File: rtl/square_renderer_hit.sv
// Per-slot bounds test: combinational, zero latency, no flow control.
// Right/bottom edges are formed one bit wider so squares near the limit clip instead of wrapping.
module square_hit
    import square_renderer_pkg::*;
#(
    parameter int COORD_W = VGA_COORD_W,
    parameter int SQ_SIZE = 10
) (
    input  logic               en,
    input  logic [COORD_W-1:0] x_left,
    input  logic [COORD_W-1:0] y_top,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);

    localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(SQ_SIZE - 1);

    logic [COORD_W:0] x_right;
    logic [COORD_W:0] y_bottom;

    assign x_right  = {1'b0, x_left} + SPAN;
    assign y_bottom = {1'b0, y_top} + SPAN;

    assign hit = en
              && (x >= x_left) && ({1'b0, x} <= x_right)
              && (y >= y_top)  && ({1'b0, y} <= y_bottom);

endmodule

// File: rtl/square_renderer.sv
// Renders NUM_SQUARES prioritised squares over a background; 3 clk from x/y/video_on to rgb.
// Writes always accepted except on frame_start when a commit is or would become pending.
module square_renderer
    import square_renderer_pkg::*;
#(
    parameter int NUM_SQUARES = 16,
    parameter int SQ_SIZE     = 10,
    parameter int COORD_W     = VGA_COORD_W,
    parameter int RGB_W       = DEF_RGB_W,
    parameter logic [RGB_W-1:0] BG_RGB = RGB_W'(DEF_BG_RGB),
    parameter int IDX_W       = $clog2(NUM_SQUARES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_on,
    input  logic [COORD_W-1:0]            x,
    input  logic [COORD_W-1:0]            y,
    input  logic                          frame_start,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [IDX_W-1:0]              wr_addr,
    input  logic [1+RGB_W+2*COORD_W-1:0]  wr_data,
    output logic [RGB_W-1:0]              rgb,
    output logic                          rgb_valid,
    output logic                          committed,
    output logic                          collision
);

    localparam int AW = attr_w(COORD_W, RGB_W);
    localparam int YL = y_lsb(COORD_W);
    localparam int CL = rgb_lsb(COORD_W);
    localparam int EB = en_bit(COORD_W, RGB_W);
    localparam logic [IDX_W:0] NUM_EXT = (IDX_W+1)'(NUM_SQUARES);

    logic [AW-1:0] shadow [NUM_SQUARES];
    logic [AW-1:0] active [NUM_SQUARES];
    logic          pending;
    logic          in_range;
    logic          wr_fire;
    logic          commit;

    assign in_range = {1'b0, wr_addr} < NUM_EXT;
    // Stall the write on a commit edge so shadow never changes while being copied.
    assign wr_ready = !(frame_start && (pending || (wr_valid && in_range)));
    assign wr_fire  = wr_valid && wr_ready && in_range;
    assign commit   = frame_start && pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SQUARES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending   <= 1'b0;
            committed <= 1'b0;
        end else begin
            committed <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_SQUARES; i++) active[i] <= shadow[i];
                pending <= 1'b0;
            end
            if (wr_fire) begin
                shadow[wr_addr] <= wr_data;
                pending         <= 1'b1;
            end
        end
    end

    logic [COORD_W-1:0]     x1;
    logic [COORD_W-1:0]     y1;
    logic                   von1;
    logic [NUM_SQUARES-1:0] hit;
    logic [RGB_W-1:0]       win_col;
    logic                   multi;

    for (genvar g = 0; g < NUM_SQUARES; g++) begin : g_hit
        square_hit #(
            .COORD_W (COORD_W),
            .SQ_SIZE (SQ_SIZE)
        ) u_hit (
            .en     (active[g][EB]),
            .x_left (active[g][X_LSB +: COORD_W]),
            .y_top  (active[g][YL +: COORD_W]),
            .x      (x1),
            .y      (y1),
            .hit    (hit[g])
        );
    end

    always_comb begin
        win_col = '0;
        for (int i = NUM_SQUARES - 1; i >= 0; i--) begin
            if (hit[i]) win_col = active[i][CL +: RGB_W];
        end
    end

    // Clearing the lowest set bit leaves something only if two or more slots hit.
    assign multi = |(hit & (hit - NUM_SQUARES'(1)));

    logic [RGB_W-1:0] col2;
    logic             any2;
    logic             multi2;
    logic             von2;
    logic             flag;
    logic             set_now;

    assign set_now = von2 && multi2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1        <= '0;
            y1        <= '0;
            von1      <= 1'b0;
            col2      <= '0;
            any2      <= 1'b0;
            multi2    <= 1'b0;
            von2      <= 1'b0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
            flag      <= 1'b0;
            collision <= 1'b0;
        end else begin
            x1        <= x;
            y1        <= y;
            von1      <= video_on;
            col2      <= win_col;
            any2      <= |hit;
            multi2    <= multi;
            von2      <= von1;
            rgb_valid <= von2;
            rgb       <= !von2 ? '0 : (any2 ? col2 : BG_RGB);
            if (frame_start) begin
                collision <= flag;
                flag      <= set_now;
            end else if (set_now) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/square_renderer.md
Name: square_renderer

Overview:
- Parametrised successor to the fixed 16-square pixel generator; renders up to NUM_SQUARES axis-aligned squares over a background colour.
- Each square has its own position, colour and enable.
- Square attributes are written into a shadow table through a valid/ready port. The shadow table is committed to the active table only at frame start, so updates never tear.
- Sits between the VGA controller and the RGB output pins. It also reports per-frame square overlap (collision) to game logic.

Parameters:
- NUM_SQUARES, 16, number of square slots; 2..64.
- SQ_SIZE, 10, side length in pixels, common to all squares; 1..64.
- COORD_W, 10, width of x/y coordinates.
- RGB_W, 12, colour width.
- BG_RGB, 12'hF00, background colour.
- IDX_W, $clog2(NUM_SQUARES), slot index width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- video_on  in  1  from VGA controller.
- x  in  COORD_W  current pixel column.
- y  in  COORD_W  current pixel row.
- frame_start  in  1  single-cycle pulse at the first pixel of a frame.
- wr_valid  in  1  attribute write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  IDX_W  slot index.
- wr_data  in  1+RGB_W+2*COORD_W  {en, colour, y_top, x_left}.
- rgb  out  RGB_W  registered pixel colour.
- rgb_valid  out  1  video_on delayed to align with rgb.
- committed  out  1  one-cycle pulse when the shadow table has been copied to active.
- collision  out  1  overlap seen in the previous frame.

Behaviour:
- Reset (async assert, sync release):
  - Shadow and active tables cleared (en=0, colour=0, x=0, y=0).
  - rgb=0, rgb_valid=0, committed=0, collision=0, wr_ready=1.
  - Pending flag cleared; pipeline regs cleared.
- Write port:
  - Accepted write updates shadow[wr_addr] on the same edge and sets the sticky pending flag.
  - wr_addr >= NUM_SQUARES: the write is accepted and dropped, and pending is not set.
  - wr_ready=0 only in a cycle where frame_start=1 && (pending || accepted write would set it). The write is not taken that cycle and must be held by the master; it takes effect next cycle.
- Commit:
  - On frame_start with pending=1: active <= shadow (all slots, one cycle), pending <= 0, committed pulses on the next cycle.
  - frame_start with pending=0: no copy, no pulse.
- Pixel pipeline, fixed latency 3 clk from x/y/video_on to rgb/rgb_valid:
  - S1: register x, y, video_on.
  - S2: per slot, hit[i] = en[i] && x_left<=x<=x_left+SQ_SIZE-1 && y_top<=y<=y_top+SQ_SIZE-1.
    - Edge sums are computed in COORD_W+1 bits and never wrap. A square at x_left=1020 with SQ_SIZE=10 covers 1020..1023 only.
  - S3: priority select, lowest index with hit wins.
    - rgb = 0 if !video_on_d.
    - Otherwise rgb = colour of the winning slot if any hit.
    - Otherwise rgb = BG_RGB.
  - Active-table change at commit affects pixels whose S2 occurs after the commit edge; no pixel mixes old and new tables.
- Collision:
  - Internal sticky flag sets in S3 when video_on_d && popcount(hit) >= 2.
  - On frame_start: collision <= flag, and flag <= 0. Coincident set and clear is resolved as clear-then-set for the current pixel.
  - A collision in frame N is therefore visible through frame N+1.

Decomposition:
- Shared package holds:
  - the attribute record layout: field offsets for en, colour, y, x;
  - ATTR_W;
  - default BG_RGB;
  - the VGA coordinate width.
- One natural sub-module: square_hit. Per-slot bounds compare, combinational, instantiated NUM_SQUARES times by generate.
- Priority select, collision and the tables stay in the top.

Test Plan:
- Reset mid-frame with rgb showing colour 0x0F0 -> rgb=0, rgb_valid=0 immediately, with no clk edge required. After release, an empty table gives rgb=0xF00 at visible pixels 3 clk later.
- Write slot 3 {1, 0x0FF, y=100, x=200} plus frame_start -> committed pulses. In the next frame, pixels (200..209, 100..109) give 0x0FF; (210,100) and (199,100) give 0xF00.
- Slots 1 (0x00F) and 5 (0xF0F) both at (50,50) -> (55,55) outputs 0x00F. collision=1 after the following frame_start and clears after one more collision-free frame.
- wr_valid held on the frame_start cycle with pending=1 -> wr_ready=0 that cycle, write accepted next cycle, and the new value is not shown until the following commit.
- x_left=1020, y_top=470, SQ_SIZE=10 -> x=1023 hits, x=0 (wrap) does not; wr_addr=NUM_SQUARES -> no table change and no commit.
- video_on=0 with a square covering (x,y) -> rgb=0 and rgb_valid=0, with 3-cycle alignment checked against the video_on edges.
